// File: rtl/mod_reduce_pkg.sv
// Shared types and elaboration helpers for the serial residue engine.
// Table and legality functions are evaluated at elaboration only.
package mod_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // (a * 2**chunk) mod modulus, one ROM entry
  function automatic int fold_rom(input int a, input int chunk,
                                  input int modulus);
    longint p;
    p = longint'(a) << chunk;
    return int'(p % longint'(modulus));
  endfunction

  // a chunk may never exceed the modulus, so one subtract suffices
  function automatic bit chunk_ok(input int chunk, input int modulus);
    return (chunk >= 1) && ((longint'(1) << chunk) <= longint'(modulus));
  endfunction

endpackage

// File: rtl/mod_reduce_serial_step.sv
// One Horner step: acc_out = (acc_in * 2**CHUNK + chunk) mod MOD.
// ROM lookup plus a single conditional subtract; acc_in < MOD assumed.
module mod_horner_step
  import mod_reduce_pkg::*;
#(
  parameter int MOD   = 241,
  parameter int CHUNK = 6,
  parameter int RW    = $clog2(MOD)
) (
  input  logic [RW-1:0]    acc_in,
  input  logic [CHUNK-1:0] chunk,
  output logic [RW-1:0]    acc_out
);

  logic [RW-1:0] rom [2**RW];
  logic [RW:0]   sum;

  for (genvar a = 0; a < 2**RW; a++) begin : g_rom
    if (a < MOD) begin : g_used
      assign rom[a] = RW'(fold_rom(a, CHUNK, MOD));
    end else begin : g_unused
      assign rom[a] = '0;
    end
  end

  assign sum = {1'b0, rom[acc_in]} + (RW+1)'(chunk);

  assign acc_out = (sum >= (RW+1)'(MOD))
                 ? RW'(sum - (RW+1)'(MOD))
                 : sum[RW-1:0];

endmodule

// File: rtl/mod_reduce_serial.sv
// Serial residue engine: in_data mod MOD, CHUNK bits per cycle, MSB first.
// valid/ready on both sides; back-to-back operands without an idle bubble.
module mod_reduce_serial
  import mod_reduce_pkg::*;
#(
  parameter int W     = 400,
  parameter int MOD   = 241,
  parameter int CHUNK = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(MOD)-1:0]  out_res,
  output logic                    busy
);

  localparam int RW    = $clog2(MOD);
  localparam int BEATS = ceil_div(W, CHUNK);
  localparam int SW    = BEATS * CHUNK;
  localparam int CW    = $clog2(BEATS + 1);

  if (!chunk_ok(CHUNK, MOD)) begin : g_bad_chunk
    $error("mod_reduce_serial: 2**CHUNK must not exceed MOD");
  end

  state_t          state;
  state_t          state_d;
  logic [SW-1:0]   sreg;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   acc_nx;
  logic [CW-1:0]   beat_cnt;
  logic            accept;
  logic            last_beat;

  mod_horner_step #(
    .MOD   (MOD),
    .CHUNK (CHUNK),
    .RW    (RW)
  ) u_step (
    .acc_in  (acc),
    .chunk   (sreg[SW-1 -: CHUNK]),
    .acc_out (acc_nx)
  );

  assign last_beat = (beat_cnt == CW'(BEATS - 1));
  assign busy      = (state != IDLE);

  // next state and input handshake; clear overrides everything
  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: in_ready = !clear;
      RUN: begin
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready && !clear;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) state_d = RUN;
    if (clear) state_d = IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // operand load, Horner fold, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      sreg      <= SW'(in_data);
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (state == RUN) begin
      acc      <= acc_nx;
      sreg     <= sreg << CHUNK;
      beat_cnt <= beat_cnt + CW'(1);
      if (last_beat) begin
        out_res   <= acc_nx;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_reduce_serial.sv
// Directed/table bench for mod_reduce_serial (default config plus a
// small W=13 MOD=7 CHUNK=2 instance).
module tb_mod_reduce_serial;

  localparam int W     = 400;
  localparam int BEATS = 67;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_res;
  logic          busy;

  logic          s_in_valid;
  logic          s_in_ready;
  logic [12:0]   s_in_data;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [2:0]    s_out_res;
  logic          s_busy;

  int checks;
  int errors;

  mod_reduce_serial #(.W(W), .MOD(241), .CHUNK(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  mod_reduce_serial #(.W(13), .MOD(7), .CHUNK(2)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_res   (s_out_res),
    .busy      (s_busy)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [7:0]   r;
  } vec_t;

  vec_t tab [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [W-1:0] d);
    int r;
    r = 0;
    for (int i = W - 1; i >= 0; i--) r = (r * 2 + int'(d[i])) % 241;
    return 8'(r);
  endfunction

  task automatic send(input logic [W-1:0] d);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {W{1'b1}};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid drop", out_valid, 0);
  endtask

  task automatic no_out(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check(name, seen, 0);
  endtask

  initial begin
    int lat;
    int k_out;
    int k_in;
    int last;
    int sv;
    int n;
    bit ok;
    bit acc;
    logic [W-1:0] d;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_out_ready = 1'b0;

    tab[0].d = '0;                 tab[0].r = 8'd0;
    tab[1].d = 400'd240;           tab[1].r = 8'd240;
    tab[2].d = 400'd241;           tab[2].r = 8'd0;
    tab[3].d = 400'd256;           tab[3].r = 8'd15;
    tab[4].d = 400'd241007;        tab[4].r = 8'd7;
    tab[5].d = {W{1'b1}};          tab[5].r = 8'd224;
    tab[6].d = 400'd1 << 24;       tab[6].r = 8'd1;
    tab[7].d = 400'd1 << 399;      tab[7].r = 8'd233;

    #12;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_res", out_res, 0);
    check("rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tab[i].d);
      check("run busy", busy, 1);
      wait_out(lat);
      check("latency", lat, BEATS);
      check("table res", out_res, tab[i].r);
      take();
    end

    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 13; j++) d = {d[367:0], 32'($urandom)};
      if (i % 4 == 1) d = d >> $urandom_range(399, 1);
      send(d);
      wait_out(lat);
      check("random res", out_res, model(d));
      take();
    end

    send(tab[3].d);
    wait_out(lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = tab[5].d;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!(out_valid && out_res == 8'd15 && !in_ready)) ok = 0;
    end
    check("stall hold", ok, 1);
    @(negedge clk);
    in_valid = 1'b0;
    take();
    @(posedge clk);
    #1;
    check("stall no restart", busy, 0);

    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    k_in = 0;
    k_out = 0;
    last = 0;
    in_data = tab[0].d;
    for (int c = 0; c < 500 && k_out < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("b2b res", out_res, tab[k_out % 8].r);
        check("b2b gap", c - last, 68);
        last = c;
        k_out++;
      end
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k_in++;
        in_data = tab[k_in % 8].d;
      end
    end
    check("b2b count", k_out, 5);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("b2b clear", busy, 0);

    @(negedge clk);
    in_valid = 1'b1;
    in_data = tab[3].d;
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear beats in_valid", busy, 0);
    in_valid = 1'b0;
    clear = 1'b0;

    send(tab[5].d);
    repeat (30) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear busy", busy, 0);
    no_out("clear no result");
    send(tab[3].d);
    wait_out(lat);
    check("after clear res", out_res, 15);
    take();

    send(tab[5].d);
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    no_out("rst no result");
    send(tab[3].d);
    wait_out(lat);
    check("after rst res", out_res, 15);
    take();

    s_out_ready = 1'b1;
    for (int v = 0; v < 8192 + 13; v += 13) begin
      sv = (v > 8191) ? 8191 : v;
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_data = 13'(sv);
      n = 0;
      while (!s_in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("small lat", lat, 7);
      check("small res", s_out_res, sv % 7);
    end
    s_out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
